// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and geometry constants for the 2-way, 8-set, 16-byte-line
// write-back cache control path.
package cache_types;

  localparam int CACHE_WAYS  = 2;
  localparam int OFFSET_BITS = 4;
  localparam int INDEX_BITS  = 3;

  typedef enum logic [1:0] {
    S_CHECK = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } cache_ctrl_state_t;

  function automatic logic [CACHE_WAYS-1:0] way_onehot(input logic way);
    logic [CACHE_WAYS-1:0] oh;
    oh      = '0;
    oh[way] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// Controller-side bundle: CPU handshake, datapath status/strobes and the
// physical-memory line handshake.
interface cache_ctrl_if;
  logic mem_read, mem_write, mem_resp;
  logic hit, dirty, compare0_out, compare1_out, lru_output;
  logic address_sel, data_read_sel, addr_mux_sel, data_mux_sel;
  logic load_dirty_valid0, load_dirty_valid1;
  logic load_data0, load_data1;
  logic load_tag0, load_tag1;
  logic dirty_write, load_lru, lru_in, miss;
  logic pmem_read, pmem_write, pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, dirty, compare0_out, compare1_out,
           lru_output, pmem_resp,
    output mem_resp, address_sel, data_read_sel, addr_mux_sel, data_mux_sel,
           load_dirty_valid0, load_dirty_valid1, load_data0, load_data1,
           load_tag0, load_tag1, dirty_write, load_lru, lru_in, miss,
           pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, dirty, compare0_out, compare1_out,
           lru_output, pmem_resp,
    input  mem_resp, address_sel, data_read_sel, addr_mux_sel, data_mux_sel,
           load_dirty_valid0, load_dirty_valid1, load_data0, load_data1,
           load_tag0, load_tag1, dirty_write, load_lru, lru_in, miss,
           pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_ctrl_fsm_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for the write-back cache: hit handling, victim writeback,
// line allocation and hit/miss performance counters.
module cache_ctrl_fsm
  import cache_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_ctrl_if.master         bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  cache_ctrl_state_t state, state_nxt;

  logic [CACHE_WAYS-1:0] load_data, load_tag, load_dv;
  logic resp, miss, load_lru, lru_in, dirty_write;
  logic data_read_sel, addr_mux_sel, data_mux_sel;
  logic pmem_read, pmem_write;
  logic req;

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_CHECK;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_data     = '0;
    load_tag      = '0;
    load_dv       = '0;
    resp          = 1'b0;
    miss          = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    dirty_write   = 1'b0;
    data_read_sel = 1'b0;
    addr_mux_sel  = 1'b0;
    data_mux_sel  = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    unique case (state)
      S_CHECK: begin
        if (req) begin
          if (bus.hit) begin
            resp     = 1'b1;
            load_lru = 1'b1;
            // Write wins when both request lines are (illegally) high.
            if (bus.mem_write) begin
              data_mux_sel = bus.compare1_out;
              load_data    = way_onehot(bus.compare1_out);
              load_dv      = way_onehot(bus.compare1_out);
              dirty_write  = 1'b1;
              lru_in       = ~bus.compare1_out;
            end else begin
              lru_in = bus.compare0_out;
            end
          end else begin
            miss      = 1'b1;
            state_nxt = bus.dirty ? S_WB : S_ALLOC;
          end
        end
      end

      S_WB: begin
        addr_mux_sel = 1'b1;
        data_mux_sel = bus.lru_output;
        pmem_write   = 1'b1;
        if (bus.pmem_resp) state_nxt = S_ALLOC;
      end

      S_ALLOC: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          load_data     = way_onehot(bus.lru_output);
          load_tag      = way_onehot(bus.lru_output);
          load_dv       = way_onehot(bus.lru_output);
          data_read_sel = 1'b1;
          state_nxt     = S_CHECK;
        end
      end

      default: state_nxt = S_CHECK;
    endcase

    // A reset cycle must never commit anything to the arrays or the CPU.
    if (!reset_n) begin
      load_data = '0;
      load_tag  = '0;
      load_dv   = '0;
      load_lru  = 1'b0;
      resp      = 1'b0;
      miss      = 1'b0;
    end
  end

  assign bus.mem_resp          = resp;
  assign bus.miss              = miss;
  assign bus.address_sel       = 1'b0;
  assign bus.data_read_sel     = data_read_sel;
  assign bus.addr_mux_sel      = addr_mux_sel;
  assign bus.data_mux_sel      = data_mux_sel;
  assign bus.load_data0        = load_data[0];
  assign bus.load_data1        = load_data[1];
  assign bus.load_tag0         = load_tag[0];
  assign bus.load_tag1         = load_tag[1];
  assign bus.load_dirty_valid0 = load_dv[0];
  assign bus.load_dirty_valid1 = load_dv[1];
  assign bus.dirty_write       = dirty_write;
  assign bus.load_lru          = load_lru;
  assign bus.lru_in            = lru_in;
  assign bus.pmem_read         = pmem_read;
  assign bus.pmem_write        = pmem_write;

  // Every completed access re-checks as a hit, so misses count in both.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (resp),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (miss),
    .count   (miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Random-request bench: emulated datapath arrays, a cache-level reference
// model feeding a scoreboard, and a monitor that checks each completion.
module tb_cache_ctrl_fsm;
  import cache_types::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();
  logic [15:0] hit_count, miss_count;

  cache_ctrl_fsm #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // standalone narrow counter so saturation is reachable in a short run
  logic       sc_rst_n = 1'b0;
  logic       sc_inc = 1'b0;
  logic [3:0] sc_cnt;
  sat_counter #(.WIDTH(4)) u_sc (
    .clk     (clk),
    .reset_n (sc_rst_n),
    .inc     (sc_inc),
    .count   (sc_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- emulated datapath ----------------
  logic [15:0] addr = 16'h0;
  logic [2:0]  idx;
  logic [8:0]  tg;
  assign idx = addr[OFFSET_BITS +: INDEX_BITS];
  assign tg  = addr[15:OFFSET_BITS+INDEX_BITS];

  logic [8:0] dp_tag   [8][2];
  logic       dp_valid [8][2];
  logic       dp_dirty [8][2];
  logic       dp_lru   [8];
  logic       dp_clr = 1'b1;

  assign bus.compare0_out = dp_valid[idx][0] && (dp_tag[idx][0] == tg);
  assign bus.compare1_out = dp_valid[idx][1] && (dp_tag[idx][1] == tg);
  assign bus.hit          = bus.compare0_out | bus.compare1_out;
  assign bus.lru_output   = dp_lru[idx];
  assign bus.dirty        = dp_dirty[idx][dp_lru[idx]];

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int s = 0; s < 8; s++) begin
        dp_lru[s] <= 1'b0;
        for (int k = 0; k < 2; k++) begin
          dp_valid[s][k] <= 1'b0;
          dp_dirty[s][k] <= 1'b0;
          dp_tag[s][k]   <= '0;
        end
      end
    end else begin
      if (bus.load_tag0) dp_tag[idx][0] <= tg;
      if (bus.load_tag1) dp_tag[idx][1] <= tg;
      if (bus.load_dirty_valid0) begin
        dp_valid[idx][0] <= 1'b1;
        dp_dirty[idx][0] <= bus.dirty_write;
      end
      if (bus.load_dirty_valid1) begin
        dp_valid[idx][1] <= 1'b1;
        dp_dirty[idx][1] <= bus.dirty_write;
      end
      if (bus.load_lru) dp_lru[idx] <= bus.lru_in;
    end
  end

  // ---------------- memory responder ----------------
  logic resp_r = 1'b0;
  logic stray = 1'b0;
  logic mem_hold = 1'b0;
  int   mcnt = 0;
  int   mlat = 2;
  assign bus.pmem_resp = resp_r | stray;

  always @(posedge clk) begin
    if (!(bus.pmem_read || bus.pmem_write) || resp_r || mem_hold) begin
      mcnt   <= 0;
      resp_r <= 1'b0;
    end else if (mcnt >= mlat) begin
      resp_r <= 1'b1;
      mlat   <= $urandom_range(0, 3);
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          hit;
    bit          wb;
    bit          way;
    bit          wr;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;
  exp_t sbq[$];

  logic [8:0]  m_tag   [8][2];
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  bit          m_lru   [8];
  logic [15:0] m_hits = 16'h0;
  logic [15:0] m_misses = 16'h0;

  task automatic model_req(input logic [15:0] a, input bit wr);
    exp_t e;
    int s = int'(a[6:4]);
    logic [8:0] t = a[15:7];
    int w = -1;
    for (int k = 0; k < 2; k++)
      if (m_valid[s][k] && m_tag[s][k] == t) w = k;
    e.wr  = wr;
    e.hit = (w >= 0);
    e.wb  = 1'b0;
    if (w < 0) begin
      w = int'(m_lru[s]);
      e.wb = m_valid[s][w] && m_dirty[s][w];
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = t;
      m_dirty[s][w] = 1'b0;
      if (m_misses != 16'hFFFF) m_misses++;
    end
    if (wr) m_dirty[s][w] = 1'b1;
    m_lru[s] = (w == 0);
    if (m_hits != 16'hFFFF) m_hits++;
    e.way    = w[0];
    e.hits   = m_hits;
    e.misses = m_misses;
    sbq.push_back(e);
  endtask

  task automatic do_req(input logic [15:0] a, input bit wr, input bit both);
    int n = 0;
    @(posedge clk); #1;
    addr          = a;
    bus.mem_write = wr;
    bus.mem_read  = !wr || both;
    model_req(a, wr);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_resp && n < 200);
    if (!bus.mem_resp) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_timeout: addr %0h got no mem_resp, required within 200 cycles", a);
    end
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  function automatic logic [16:0] all_out();
    return {bus.mem_resp, bus.miss, bus.pmem_read, bus.pmem_write, bus.load_lru,
            bus.lru_in, bus.address_sel, bus.addr_mux_sel, bus.data_mux_sel,
            bus.data_read_sel, bus.dirty_write, bus.load_data0, bus.load_data1,
            bus.load_dirty_valid0, bus.load_dirty_valid1, bus.load_tag0, bus.load_tag1};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    int   miss_seen = 0;
    bit   wb_seen = 0, rd_seen = 0, ld_seen = 0, ld_way = 0, cnt_pend = 0;
    logic [15:0] ph = 0, pm = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        miss_seen = 0; wb_seen = 0; rd_seen = 0; ld_seen = 0; cnt_pend = 0;
        continue;
      end
      if (cnt_pend) begin
        chk("hit_count", hit_count, ph);
        chk("miss_count", miss_count, pm);
        cnt_pend = 0;
      end
      if (bus.miss) miss_seen++;
      if (bus.pmem_write) begin
        wb_seen = 1;
        chk("wb_addr_mux", bus.addr_mux_sel, 1);
        chk("wb_data_mux", bus.data_mux_sel, bus.lru_output);
      end
      if (bus.pmem_read) begin
        rd_seen = 1;
        chk("alloc_addr_mux", bus.addr_mux_sel, 0);
      end
      if (bus.load_tag0 || bus.load_tag1) begin
        ld_seen = 1;
        ld_way  = bus.load_tag1;
        chk("alloc_strobes",
            {bus.load_data0, bus.load_data1, bus.load_dirty_valid0,
             bus.load_dirty_valid1, bus.data_read_sel, bus.dirty_write},
            ld_way ? 6'b010110 : 6'b101010);
      end
      if (bus.mem_resp) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_resp: got mem_resp, required none outstanding");
        end else begin
          e = sbq.pop_front();
          chk("miss_pulses", miss_seen, e.hit ? 0 : 1);
          chk("writeback", wb_seen, e.wb);
          chk("alloc_read", rd_seen, !e.hit);
          chk("alloc_loaded", ld_seen, !e.hit);
          if (!e.hit) chk("alloc_way", ld_way, e.way);
          chk("lru_update", {bus.load_lru, bus.lru_in}, {1'b1, !e.way});
          if (e.wr)
            chk("wr_hit_strobes",
                {bus.load_data0, bus.load_data1, bus.load_dirty_valid0, bus.load_dirty_valid1,
                 bus.dirty_write, bus.data_read_sel, bus.data_mux_sel},
                e.way ? 7'b0101101 : 7'b1010100);
          else
            chk("rd_hit_no_write",
                {bus.load_data0, bus.load_data1, bus.load_dirty_valid0, bus.load_dirty_valid1}, 0);
          ph = e.hits;
          pm = e.misses;
          cnt_pend = 1;
        end
        miss_seen = 0; wb_seen = 0; rd_seen = 0; ld_seen = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    bit wr;
    int n;
    int sx;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_valid[s][k] = 1'b0;
        m_dirty[s][k] = 1'b0;
        m_tag[s][k]   = '0;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    dp_clr   = 1'b0;
    sc_rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", dut.state, S_CHECK);
    chk("reset_outputs", all_out(), 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);

    // stray memory response while idle is ignored
    @(posedge clk); #1 stray = 1'b1;
    @(negedge clk);
    chk("stray_resp_outputs", all_out(), 0);
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    chk("stray_resp_state", dut.state, S_CHECK);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      a[15:7] = 9'($urandom_range(0, 3));
      wr = bit'($urandom_range(0, 1));
      do_req(a, wr, wr && ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      chk("array_lru", dp_lru[s], m_lru[s]);
      for (int k = 0; k < 2; k++) begin
        chk("array_valid", dp_valid[s][k], m_valid[s][k]);
        if (m_valid[s][k]) begin
          chk("array_tag", dp_tag[s][k], m_tag[s][k]);
          chk("array_dirty", dp_dirty[s][k], m_dirty[s][k]);
        end
      end
    end

    // reset while allocating: line transaction abandoned, nothing written
    mem_hold = 1'b1;
    @(posedge clk); #1;
    addr = {9'h1AB, 3'd5, 4'h0};
    bus.mem_read = 1'b1;
    n = 0;
    while (!bus.pmem_read && n < 30) begin
      @(negedge clk);
      if (bus.pmem_write) begin
        stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
      end
      n++;
    end
    chk("abort_reached_alloc", bus.pmem_read, 1);
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_read = 1'b0;
    stray = 1'b1;
    #1;
    chk("abort_no_load",
        {bus.load_data0, bus.load_data1, bus.load_tag0, bus.load_tag1,
         bus.load_dirty_valid0, bus.load_dirty_valid1, bus.load_lru}, 0);
    @(negedge clk);
    chk("abort_pmem_read_dropped", bus.pmem_read, 0);
    chk("abort_state", dut.state, S_CHECK);
    chk("abort_outputs", all_out(), 0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    stray    = 1'b0;
    mem_hold = 1'b0;
    m_hits   = 16'h0;
    m_misses = 16'h0;
    @(negedge clk);
    chk("abort_hit_count", hit_count, 0);
    chk("abort_miss_count", miss_count, 0);
    chk("abort_tag_unwritten", dp_valid[5][0] && dp_tag[5][0] == 9'h1AB, 0);
    chk("abort_tag_unwritten1", dp_valid[5][1] && dp_tag[5][1] == 9'h1AB, 0);

    // post-abort traffic still behaves, counters restart from zero
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      a[15:7] = 9'($urandom_range(0, 3));
      do_req(a, bit'($urandom_range(0, 1)), 1'b0);
    end
    repeat (2) @(negedge clk);

    // counter saturation on a narrow instance
    sx = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("sat_count", sc_cnt, sx);
      sc_inc = ($urandom_range(0, 3) != 0);
      if (sc_inc && sx != 15) sx++;
    end
    @(negedge clk);
    chk("sat_count_final", sc_cnt, sx);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Control FSM that sequences the 2-way, 8-set, 16-byte-line write-back cache datapath.
- Decodes CPU read/write requests against the hit/dirty/LRU status from the datapath.
- Drives every datapath load/select strobe and runs the physical-memory handshake for line writeback and allocation.
- Keeps saturating hit and miss counters for performance analysis.

Parameters:
CNT_WIDTH, 16, width of the hit_count and miss_count saturating counters

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_resp  out  1  CPU request complete (1-cycle pulse)
hit  in  1  datapath: valid tag match in either way
dirty  in  1  datapath: dirty bit of the LRU way
compare0_out  in  1  datapath: way 0 match
compare1_out  in  1  datapath: way 1 match
lru_output  in  1  datapath: LRU (victim) way index
address_sel  out  1  tied 0
data_read_sel  out  1  0 = merged CPU write data, 1 = pmem_rdata
addr_mux_sel  out  1  0 = CPU address, 1 = victim writeback address
data_mux_sel  out  1  way feeding pmem_wdata and the overwrite merge
load_dirty_valid0/1  out  1 each  write dirty+valid for way 0/1
load_data0/1  out  1 each  write line for way 0/1
load_tag0/1  out  1 each  write tag for way 0/1
dirty_write  out  1  dirty value written with load_dirty_valid*
load_lru  out  1  update LRU array
lru_in  out  1  new LRU value
miss  out  1  1-cycle pulse per miss
pmem_read  out  1  line read request to memory
pmem_write  out  1  line write request to memory (also driven to the datapath)
pmem_resp  in  1  memory transaction complete
hit_count  out  CNT_WIDTH  saturating hit count
miss_count  out  CNT_WIDTH  saturating miss count

Behaviour:
- Reset: reset_n sampled low at posedge returns the FSM to S_CHECK and clears both counters. All outputs are combinational and default to 0.
- Reset mid-transaction: an in-flight pmem_read/pmem_write drops the next cycle. No array write is issued.
- States: S_CHECK, S_WB, S_ALLOC.
- S_CHECK, no request: all strobes 0.
- S_CHECK, read hit: mem_resp=1 in the same cycle. load_lru=1. lru_in = compare0_out (the way not hit becomes LRU). Stay in S_CHECK. hit_count increments.
- S_CHECK, write hit: let w = compare1_out.
  - data_mux_sel=w, data_read_sel=0.
  - load_data_w=1, load_dirty_valid_w=1, dirty_write=1.
  - load_lru=1, lru_in=~w, mem_resp=1, hit_count increments.
- S_CHECK, miss (request and !hit): miss=1 for one cycle, miss_count increments, no mem_resp. Next state is S_WB if dirty, else S_ALLOC.
- S_WB:
  - Drive addr_mux_sel=1, data_mux_sel=lru_output, pmem_write=1 until pmem_resp.
  - On pmem_resp go to S_ALLOC. No array writes occur in S_WB.
- S_ALLOC:
  - Drive addr_mux_sel=0, pmem_read=1.
  - On pmem_resp, with v = lru_output: load_data_v, load_tag_v, load_dirty_valid_v = 1, dirty_write=0, data_read_sel=1. Next state is S_CHECK.
  - The request then hits on re-check. The hit counts in hit_count as well, so a missing access increments both counters once.
- Request and line-transaction rules:
  - mem_read and mem_write both high is illegal; write takes priority.
  - A request dropped during S_WB/S_ALLOC does not abort the line transaction. The FSM returns to S_CHECK and idles.
  - pmem_resp outside S_WB/S_ALLOC is ignored.
- Counters: saturate at all-ones (no wrap). Each counter increments at most once per cycle.
- Latency:
  - Read/write hit: 0 cycles after the request is presented in S_CHECK.
  - Clean miss: 1 + T_mem + 1 cycles.
  - Dirty miss: 1 + 2·T_mem + 1 cycles.

Decomposition:
- Add cache_ctrl_state_t enum {S_CHECK, S_WB, S_ALLOC} to the cache_types package.
- Add constant CACHE_WAYS=2 to the cache_types package.
- Sub-module sat_counter (parameter WIDTH; inputs clk, reset_n, inc; output count), instantiated twice for hit_count and miss_count.

Test Plan:
- Reset with reset_n=0 for 2 cycles → state S_CHECK, hit_count=0, miss_count=0, all strobes 0.
- Read 0x0010, hit=0, dirty=0; pmem_resp after 3 cycles → miss pulses once, pmem_read high 3 cycles, load_data/tag/dirty_valid of lru_output way with data_read_sel=1, then mem_resp; miss_count=1, hit_count=1.
- Write 0x0010 with hit=1, compare0_out=1 → same cycle: load_data0=1, load_dirty_valid0=1, dirty_write=1, data_read_sel=0, lru_in=1, mem_resp=1.
- Read 0x0390, miss, dirty=1, lru_output=1 → pmem_write with addr_mux_sel=1, data_mux_sel=1 until pmem_resp, then pmem_read with addr_mux_sel=0; the way-1 arrays load.
- Assert reset_n=0 during S_ALLOC → next cycle pmem_read=0, state S_CHECK, no load_* asserted.
- Preload hit_count to 0xFFFF (force), then one read hit → hit_count stays 0xFFFF.
